accel_job_ctrl: RTL and testbench
=================================

// Module: accel_job_ctrl
// PURPOSE
//  Job controller between the HPS start/done PIO pair and NUM_CH edge-detection engines.
//  A rising edge on start_export launches every enabled engine with a one-cycle pulse.
//  The block then collects per-engine done flags and counts elapsed cycles.
//  A cycle-count watchdog bounds the job, and the block reports done/status back to the HPS.
// PARAMETERS
//  NUM_CH  4   number of engine channels (1..16)
//  CNT_W   32  width of cycle counter and timeout_cycles
// PORTS
//  clk_clk          in   1       system clock; everything synchronous to it
//  reset_reset_n    in   1       asynchronous active-low reset
//  start_export     in   1       HPS start level; rising edge requests a job
//  ch_enable        in   NUM_CH  channel mask, sampled on accepted start
//  timeout_cycles   in   CNT_W   watchdog limit in WAIT cycles; 0 = disabled
//  eng_start        out  NUM_CH  one-cycle launch pulse per enabled engine
//  eng_done         in   NUM_CH  engine done (pulse or level), sampled in WAIT only
//  done_export      out  1       job finished; held until start_export low
//  busy             out  1       high in LAUNCH and WAIT
//  done_mask        out  NUM_CH  engines that have reported done this job
//  timed_out        out  1       job ended by watchdog
//  cycle_count      out  CNT_W   WAIT cycles elapsed (saturating)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, internal mask 0, start_d=1.
//   start_d resets to 1 so a start held high through reset does not launch a job.
//  start_d = start_export registered every cycle in every state; rise = start_export & ~start_d.
//  FSM IDLE/LAUNCH/WAIT/DONE:
//   IDLE: on rise, mask<=ch_enable.
//    If ch_enable==0: go to DONE directly; cycle_count=0, timed_out=0, done_mask=0.
//    Otherwise: go to LAUNCH. No other transitions from IDLE.
//   LAUNCH (1 cycle): eng_start=mask (registered output, high this cycle only).
//    Clear done_mask, cycle_count and timed_out; go to WAIT.
//    eng_done is ignored in this cycle.
//   WAIT: each cycle:
//    - cycle_count += 1, saturating at all-ones.
//    - nxt = done_mask | (eng_done & mask); done_mask<=nxt.
//    - eng_done bits outside mask are ignored.
//    - If nxt==mask: go to DONE, timed_out=0.
//    - Else if timeout_cycles!=0 && cycle_count+1==timeout_cycles: go to DONE, timed_out=1.
//    - Completion and timeout on the same cycle: completion wins (timed_out=0).
//   DONE: done_export=1.
//    When start_export is sampled low: go to IDLE, and done_export=0 the following cycle.
//  Latency:
//   - Start sampled high at edge k: eng_start high during cycle k+1 (LAUNCH).
//   - Last done sampled at edge m: done_export high from m+1.
//   - cycle_count final value = number of WAIT cycles, including the completing cycle.
//  Ignored inputs:
//   - A rise during LAUNCH/WAIT/DONE is ignored; a new job needs start low, then high, while in IDLE.
//   - ch_enable changes after acceptance have no effect on the current job.
//  Status hold: done_mask, timed_out and cycle_count hold their values through DONE and IDLE
//   until the next LAUNCH clears them.
//  busy = (state==LAUNCH)|(state==WAIT), registered.
//  Reset mid-job: immediate return to reset values; engines get no further pulses;
//   partially collected status is lost.
// TESTING
//  1 NUM_CH=4, ch_enable=1011, timeout=0, rise; done ch0@W3, ch1@W5, ch3@W9
//    -> eng_start=1011 for 1 cycle; done_export high after W9; cycle_count=9;
//       done_mask=1011; timed_out=0.
//  2 ch_enable=0111, timeout_cycles=16, ch2 silent
//    -> DONE after 16 WAIT cycles; timed_out=1; done_mask=0011; cycle_count=16.
//  3 timeout_cycles=8, final done arrives in WAIT cycle 8
//    -> timed_out=0; done_mask=mask; cycle_count=8.
//  4 ch_enable=0000, rise
//    -> no eng_start pulse; done_export high 1 cycle after the rise is sampled;
//       cycle_count=0; busy never high.
//  5 Extra stimulus in WAIT: pulse eng_done[2] with mask=1011, and toggle start low/high
//    -> bit2 not set; no relaunch; only the normal completion ends the job.
//  6 Assert reset_n low mid-WAIT with start held high, then release
//    -> outputs 0 asynchronously; after release no launch until start goes low then high;
//       next job runs normally.

Source files
------------

// File: rtl/accel_job_ctrl.sv
// accel_job_ctrl
//   Job controller between the HPS start/done PIO pair and NUM_CH engines.
//   A rising edge on start_export, seen while idle, launches every enabled
//   engine with a one-cycle pulse. The block then collects per-engine done
//   flags and counts WAIT cycles, with an optional cycle-count watchdog.
//   Completion or timeout raises done_export until start_export drops.
// Ports
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   start_export           : HPS start level (rising edge requests a job)
//   ch_enable              : channel mask, sampled when a start is accepted
//   timeout_cycles         : watchdog limit in WAIT cycles, 0 disables
//   eng_start              : one-cycle launch pulse per enabled engine
//   eng_done               : engine done flags, sampled in WAIT only
//   done_export            : job finished, held until start_export low
//   busy                   : high in LAUNCH and WAIT
//   done_mask              : engines that reported done this job
//   timed_out              : job ended by the watchdog
//   cycle_count            : WAIT cycles elapsed, saturating
module accel_job_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start_export,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [CNT_W-1:0]  timeout_cycles,
  output logic [NUM_CH-1:0] eng_start,
  input  logic [NUM_CH-1:0] eng_done,
  output logic              done_export,
  output logic              busy,
  output logic [NUM_CH-1:0] done_mask,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_start_d;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [NUM_CH-1:0] r_eng_start, w_eng_start_nxt;
  logic              r_done_export, w_done_export_nxt;
  logic              r_busy, w_busy_nxt;
  logic [NUM_CH-1:0] r_done_mask, w_done_mask_nxt;
  logic              r_timed_out, w_timed_out_nxt;
  logic [CNT_W-1:0]  r_cycle_count, w_cycle_count_nxt;

  logic              w_rise;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_sat;
  logic [NUM_CH-1:0] w_collected;

  assign w_rise      = start_export & ~r_start_d;
  assign w_cnt_inc   = r_cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_cnt_sat   = (&r_cycle_count) ? r_cycle_count : w_cnt_inc;
  assign w_collected = r_done_mask | (eng_done & r_mask);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state       <= S_IDLE;
      // Reset high so a start level held through reset is not seen as a rise.
      r_start_d     <= 1'b1;
      r_mask        <= '0;
      r_eng_start   <= '0;
      r_done_export <= 1'b0;
      r_busy        <= 1'b0;
      r_done_mask   <= '0;
      r_timed_out   <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_d     <= start_export;
      r_mask        <= w_mask_nxt;
      r_eng_start   <= w_eng_start_nxt;
      r_done_export <= w_done_export_nxt;
      r_busy        <= w_busy_nxt;
      r_done_mask   <= w_done_mask_nxt;
      r_timed_out   <= w_timed_out_nxt;
      r_cycle_count <= w_cycle_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_mask_nxt        = r_mask;
    w_eng_start_nxt   = '0;
    w_done_export_nxt = r_done_export;
    w_done_mask_nxt   = r_done_mask;
    w_timed_out_nxt   = r_timed_out;
    w_cycle_count_nxt = r_cycle_count;

    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_mask_nxt = ch_enable;
          if (ch_enable == '0) begin
            w_state_nxt       = S_DONE;
            w_done_export_nxt = 1'b1;
            w_done_mask_nxt   = '0;
            w_timed_out_nxt   = 1'b0;
            w_cycle_count_nxt = '0;
          end else begin
            w_state_nxt     = S_LAUNCH;
            w_eng_start_nxt = ch_enable;
          end
        end
      end
      S_LAUNCH: begin
        w_state_nxt       = S_WAIT;
        w_done_mask_nxt   = '0;
        w_timed_out_nxt   = 1'b0;
        w_cycle_count_nxt = '0;
      end
      S_WAIT: begin
        w_cycle_count_nxt = w_cnt_sat;
        w_done_mask_nxt   = w_collected;
        // Completion is tested first so it wins over a same-cycle timeout.
        // The watchdog compares against the unsaturated increment.
        if (w_collected == r_mask) begin
          w_state_nxt       = S_DONE;
          w_done_export_nxt = 1'b1;
          w_timed_out_nxt   = 1'b0;
        end else if ((timeout_cycles != '0) && (w_cnt_inc == timeout_cycles)) begin
          w_state_nxt       = S_DONE;
          w_done_export_nxt = 1'b1;
          w_timed_out_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        if (!start_export) begin
          w_state_nxt       = S_IDLE;
          w_done_export_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_WAIT);
  end

  assign eng_start   = r_eng_start;
  assign done_export = r_done_export;
  assign busy        = r_busy;
  assign done_mask   = r_done_mask;
  assign timed_out   = r_timed_out;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_accel_job_ctrl.sv
module tb_accel_job_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 8;

  typedef struct {
    logic [NCH-1:0] dm;
    logic           to;
    logic [CW-1:0]  cc;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] edone = '0;
  logic [CW-1:0]  tmo = '0;

  logic [NCH-1:0] eng_start;
  logic           done_export;
  logic           busy;
  logic [NCH-1:0] done_mask;
  logic           timed_out;
  logic [CW-1:0]  cycle_count;

  int total = 0;
  int bad = 0;

  res_t           exp_q[$];
  logic [NCH-1:0] launch_q[$];
  logic           prev_done = 1'b0;
  logic           busy_seen = 1'b0;
  res_t           mon_r;
  logic [NCH-1:0] mon_l;

  always #5 clk = ~clk;

  accel_job_ctrl #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .start_export   (start),
    .ch_enable      (en),
    .timeout_cycles (tmo),
    .eng_start      (eng_start),
    .eng_done       (edone),
    .done_export    (done_export),
    .busy           (busy),
    .done_mask      (done_mask),
    .timed_out      (timed_out),
    .cycle_count    (cycle_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks launch pulses and job results whenever the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (eng_start != '0) begin
        if (launch_q.size() == 0) begin
          chk("unexpected_eng_start", 32'(eng_start), 32'd0);
        end else begin
          mon_l = launch_q.pop_front();
          chk("eng_start", 32'(eng_start), 32'(mon_l));
        end
      end
      if (done_export && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done_export), 32'd0);
        end else begin
          mon_r = exp_q.pop_front();
          chk("res_done_mask", 32'(done_mask), 32'(mon_r.dm));
          chk("res_timed_out", 32'(timed_out), 32'(mon_r.to));
          chk("res_cycle_count", 32'(cycle_count), 32'(mon_r.cc));
          chk("res_busy_low", 32'(busy), 32'd0);
        end
      end
    end
    prev_done = done_export;
  end

  // dN = WAIT cycle in which channel N pulses done (0 = never); tog = WAIT
  // cycle in which start is dropped for one cycle (0 = never).
  task automatic run_job(input string tag, input logic [NCH-1:0] m, input logic [CW-1:0] to,
                         input int n, input int d0, input int d1, input int d2, input int d3,
                         input int tog, input logic [NCH-1:0] xdm, input logic xto,
                         input logic [CW-1:0] xcc);
    res_t r;
    r.dm = xdm; r.to = xto; r.cc = xcc;
    @(negedge clk);
    en = m; tmo = to; start = 1'b1; edone = '0;
    launch_q.push_back(m);
    exp_q.push_back(r);
    @(negedge clk);
    // LAUNCH cycle: done flags and a changed enable must both be ignored.
    chk({tag, "_busy_launch"}, 32'(busy), 32'd1);
    en = ~m; edone = '1;
    for (int w = 1; w <= n; w++) begin
      @(negedge clk);
      chk({tag, "_done_low_wait"}, 32'(done_export), 32'd0);
      edone = {(d3 == w), (d2 == w), (d1 == w), (d0 == w)};
      start = (w == tog) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    edone = '0;
    chk({tag, "_done_latency"}, 32'(done_export), 32'd1);
    @(negedge clk);
    chk({tag, "_done_held"}, 32'(done_export), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_release"}, 32'(done_export), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold_mask"}, 32'(done_mask), 32'(xdm));
    chk({tag, "_hold_to"}, 32'(timed_out), 32'(xto));
    chk({tag, "_hold_cnt"}, 32'(cycle_count), 32'(xcc));
  endtask

  initial begin
    res_t r0;
    #2;
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_done", 32'(done_export), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask", 32'(done_mask), 32'd0);
    chk("rst_to", 32'(timed_out), 32'd0);
    chk("rst_cnt", 32'(cycle_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job("t1", 4'b1011, 8'd0, 9, 3, 5, 0, 9, 0, 4'b1011, 1'b0, 8'd9);
    run_job("t2", 4'b0111, 8'd16, 16, 2, 4, 0, 0, 0, 4'b0011, 1'b1, 8'd16);
    run_job("t3", 4'b1111, 8'd8, 8, 1, 3, 5, 8, 0, 4'b1111, 1'b0, 8'd8);

    // Empty enable mask: straight to DONE with cleared status, no busy.
    @(negedge clk);
    busy_seen = 1'b0;
    en = 4'b0000; tmo = 8'd0; start = 1'b1;
    r0.dm = '0; r0.to = 1'b0; r0.cc = '0;
    exp_q.push_back(r0);
    @(negedge clk);
    chk("t4_done_latency", 32'(done_export), 32'd1);
    chk("t4_no_eng_start", 32'(eng_start), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t4_done_release", 32'(done_export), 32'd0);
    chk("t4_busy_never", 32'(busy_seen), 32'd0);

    // Out-of-mask done pulse and start toggle during WAIT.
    run_job("t5", 4'b1011, 8'd0, 6, 2, 4, 3, 6, 3, 4'b1011, 1'b0, 8'd6);

    // Reset in the middle of WAIT with start held high.
    @(negedge clk);
    en = 4'b1111; tmo = 8'd0; start = 1'b1; edone = '0;
    launch_q.push_back(4'b1111);
    @(negedge clk);
    @(negedge clk);
    edone = 4'b0001;
    @(negedge clk);
    edone = 4'b0000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_eng_start", 32'(eng_start), 32'd0);
    chk("t6_rst_done", 32'(done_export), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_mask", 32'(done_mask), 32'd0);
    chk("t6_rst_to", 32'(timed_out), 32'd0);
    chk("t6_rst_cnt", 32'(cycle_count), 32'd0);
    @(negedge clk);
    busy_seen = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_relaunch", 32'(busy_seen), 32'd0);
    chk("t6_done_low", 32'(done_export), 32'd0);
    start = 1'b0;
    run_job("t6b", 4'b1100, 8'd0, 2, 0, 0, 1, 2, 0, 4'b1100, 1'b0, 8'd2);

    // Counter saturation with the watchdog disabled.
    run_job("t7", 4'b0001, 8'd0, 300, 300, 0, 0, 0, 0, 4'b0001, 1'b0, 8'd255);

    repeat (2) @(negedge clk);
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    chk("pending_launches", 32'(launch_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
